// File: rtl/pisca_sequenciador_pkg.sv
// Shared types and pattern constants for the pisca-pisca LED sequencer.
package pisca_pkg;

  typedef enum logic [1:0] {
    CHASE_DIR = 2'd0,
    CHASE_ESQ = 2'd1,
    VAI_VEM   = 2'd2,
    ENCHER    = 2'd3
  } modo_t;

  localparam logic [7:0] INICIO_DIREITA  = 8'h80;
  localparam logic [7:0] INICIO_ESQUERDA = 8'h01;
  localparam logic [7:0] VAZIO           = 8'h00;
  localparam logic [7:0] CHEIO           = 8'hFF;

endpackage

// File: rtl/pisca_sequenciador_divisor_tick.sv
// Prescaler: one-cycle tick every TICK_DIV clk_2 cycles; frozen by parar, cleared on mode entry.
module divisor_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_2,
  input  logic reset,
  input  logic parar,
  input  logic limpar,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = !parar && (cnt == ULTIMO);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (limpar) begin
      cnt <= '0;
    end else if (!parar) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pisca_sequenciador.sv
// Pattern/mode sequencer for the 8-LED pisca-pisca: manual or automatic rotation of four patterns.
module pisca_sequenciador
  import pisca_pkg::*;
#(
  parameter int NBITS_PISCA     = 8,
  parameter int TICK_DIV        = 4,
  parameter int PASSOS_POR_MODO = 16
) (
  input  logic                               clk_2,
  input  logic                               reset,
  input  logic                               parar,
  input  logic                               auto,
  input  logic [1:0]                         modo_sel,
  output logic [NBITS_PISCA-1:0]             led,
  output logic [1:0]                         modo_atual,
  output logic [$clog2(PASSOS_POR_MODO)-1:0] passo,
  output logic                               fim_ciclo
);

  localparam int PW = $clog2(PASSOS_POR_MODO);
  localparam logic [PW-1:0] ULTIMO_PASSO = PW'(PASSOS_POR_MODO - 1);

  modo_t                  modo_q, modo_n;
  logic [NBITS_PISCA-1:0] led_q, led_n;
  logic [PW-1:0]          passo_q, passo_n;
  logic                   esq_q, esq_n;   // bounce direction: 1 = moving left
  logic                   fim_q, fim_n;
  logic                   entrada;
  logic                   tick;
  logic [1:0]             modo_seguinte;

  divisor_tick #(.TICK_DIV(TICK_DIV)) u_divisor (
    .clk_2  (clk_2),
    .reset  (reset),
    .parar  (parar),
    .limpar (entrada),
    .tick   (tick)
  );

  assign modo_seguinte = 2'(modo_q) + 2'd1;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    modo_n  = modo_q;
    led_n   = led_q;
    passo_n = passo_q;
    esq_n   = esq_q;
    fim_n   = 1'b0;
    entrada = 1'b0;

    if (!auto && (modo_sel != 2'(modo_q))) begin
      modo_n  = modo_t'(modo_sel);
      entrada = 1'b1;
    end else if (tick) begin
      if (auto && (passo_q == ULTIMO_PASSO)) begin
        modo_n  = modo_t'(modo_seguinte);
        entrada = 1'b1;
        fim_n   = (modo_q == ENCHER);
      end else begin
        if (auto || (passo_q != ULTIMO_PASSO)) begin
          passo_n = passo_q + 1'b1;
        end
        unique case (modo_q)
          CHASE_DIR: led_n = (led_q == INICIO_ESQUERDA) ? INICIO_DIREITA : (led_q >> 1);
          CHASE_ESQ: led_n = (led_q == INICIO_DIREITA) ? INICIO_ESQUERDA : (led_q << 1);
          VAI_VEM: begin
            // Reverse on the step after an end value so each end is shown exactly once.
            if (esq_q) begin
              if (led_q == INICIO_DIREITA) begin
                led_n = led_q >> 1;
                esq_n = 1'b0;
              end else begin
                led_n = led_q << 1;
              end
            end else begin
              if (led_q == INICIO_ESQUERDA) begin
                led_n = led_q << 1;
                esq_n = 1'b1;
              end else begin
                led_n = led_q >> 1;
              end
            end
          end
          ENCHER: led_n = (led_q == CHEIO) ? VAZIO : ((led_q << 1) | INICIO_ESQUERDA);
          default: led_n = led_q;
        endcase
      end
    end

    if (entrada) begin
      passo_n = '0;
      esq_n   = 1'b1;
      unique case (modo_n)
        CHASE_DIR: led_n = INICIO_DIREITA;
        CHASE_ESQ: led_n = INICIO_ESQUERDA;
        VAI_VEM:   led_n = INICIO_ESQUERDA;
        ENCHER:    led_n = VAZIO;
        default:   led_n = INICIO_DIREITA;
      endcase
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      modo_q  <= CHASE_DIR;
      led_q   <= INICIO_DIREITA;
      passo_q <= '0;
      esq_q   <= 1'b1;
      fim_q   <= 1'b0;
    end else begin
      modo_q  <= modo_n;
      led_q   <= led_n;
      passo_q <= passo_n;
      esq_q   <= esq_n;
      fim_q   <= fim_n;
    end
  end

  assign led        = led_q;
  assign modo_atual = 2'(modo_q);
  assign passo      = passo_q;
  assign fim_ciclo  = fim_q;

endmodule

// File: tb/tb_pisca_sequenciador.sv
// Directed self-checking bench for pisca_sequenciador (TICK_DIV=4, PASSOS_POR_MODO=16).
module tb_pisca_sequenciador;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       parar;
  logic       auto;
  logic [1:0] modo_sel;
  logic [7:0] led;
  logic [1:0] modo_atual;
  logic [3:0] passo;
  logic       fim_ciclo;

  int checks   = 0;
  int failures = 0;

  pisca_sequenciador #(
    .NBITS_PISCA     (8),
    .TICK_DIV        (4),
    .PASSOS_POR_MODO (16)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .parar      (parar),
    .auto       (auto),
    .modo_sel   (modo_sel),
    .led        (led),
    .modo_atual (modo_atual),
    .passo      (passo),
    .fim_ciclo  (fim_ciclo)
  );

  always #5 clk_2 = ~clk_2;

  // Leaves the bench on a negedge with reset released; the first posedge after it counts as cycle 1.
  task automatic apply_reset();
    @(negedge clk_2) reset = 1'b1;
    @(negedge clk_2) reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (led !== 8'h80) begin failures++; $display("FAIL reset_led got=%h exp=80", led); end
    checks++; if (modo_atual !== 2'd0) begin failures++; $display("FAIL reset_modo got=%0d exp=0", modo_atual); end
    checks++; if (passo !== 4'd0) begin failures++; $display("FAIL reset_passo got=%0d exp=0", passo); end
    checks++; if (fim_ciclo !== 1'b0) begin failures++; $display("FAIL reset_fim got=%b exp=0", fim_ciclo); end
    modo_sel = 2'd3;
    apply_reset();
    repeat (9) @(negedge clk_2);
    checks++; if (led !== 8'h03) begin failures++; $display("FAIL midrun_led got=%h exp=03", led); end
    checks++; if (modo_atual !== 2'd3) begin failures++; $display("FAIL midrun_modo got=%0d exp=3", modo_atual); end
    @(posedge clk_2);
    #2 reset = 1'b1;
    #1;
    checks++; if (led !== 8'h80) begin failures++; $display("FAIL async_reset_led got=%h exp=80", led); end
    checks++; if (modo_atual !== 2'd0) begin failures++; $display("FAIL async_reset_modo got=%0d exp=0", modo_atual); end
    checks++; if (passo !== 4'd0) begin failures++; $display("FAIL async_reset_passo got=%0d exp=0", passo); end
    checks++; if (fim_ciclo !== 1'b0) begin failures++; $display("FAIL async_reset_fim got=%b exp=0", fim_ciclo); end
  endtask

  task automatic test_chase_dir();
    logic [7:0] exp_seq [0:8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    modo_sel = 2'd0;
    apply_reset();
    checks++; if (led !== exp_seq[0]) begin failures++; $display("FAIL chase_dir_start got=%h exp=%h", led, exp_seq[0]); end
    repeat (3) @(negedge clk_2);
    checks++; if (led !== 8'h80) begin failures++; $display("FAIL chase_dir_hold got=%h exp=80", led); end
    @(negedge clk_2);
    checks++; if (led !== exp_seq[1]) begin failures++; $display("FAIL chase_dir_step1 got=%h exp=%h", led, exp_seq[1]); end
    for (int s = 2; s <= 8; s++) begin
      repeat (4) @(negedge clk_2);
      checks++; if (led !== exp_seq[s]) begin failures++; $display("FAIL chase_dir_step%0d got=%h exp=%h", s, led, exp_seq[s]); end
    end
    checks++; if (passo !== 4'd8) begin failures++; $display("FAIL chase_dir_passo got=%0d exp=8", passo); end
  endtask

  task automatic test_bounce_fill();
    logic [7:0] vai [0:16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                               8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    logic [7:0] enc [0:9]  = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
    modo_sel = 2'd2;
    apply_reset();
    @(negedge clk_2);
    checks++; if (led !== vai[0]) begin failures++; $display("FAIL vai_vem_entry got=%h exp=%h", led, vai[0]); end
    checks++; if (modo_atual !== 2'd2) begin failures++; $display("FAIL vai_vem_modo got=%0d exp=2", modo_atual); end
    for (int s = 1; s <= 16; s++) begin
      repeat (4) @(negedge clk_2);
      checks++; if (led !== vai[s]) begin failures++; $display("FAIL vai_vem_step%0d got=%h exp=%h", s, led, vai[s]); end
    end
    checks++; if (passo !== 4'd15) begin failures++; $display("FAIL passo_saturate got=%0d exp=15", passo); end
    modo_sel = 2'd3;
    @(negedge clk_2);
    checks++; if (led !== enc[0]) begin failures++; $display("FAIL encher_entry got=%h exp=%h", led, enc[0]); end
    checks++; if (passo !== 4'd0) begin failures++; $display("FAIL encher_passo0 got=%0d exp=0", passo); end
    for (int s = 1; s <= 9; s++) begin
      repeat (4) @(negedge clk_2);
      checks++; if (led !== enc[s]) begin failures++; $display("FAIL encher_step%0d got=%h exp=%h", s, led, enc[s]); end
    end
  endtask

  task automatic test_freeze();
    modo_sel = 2'd1;
    apply_reset();
    @(negedge clk_2);
    checks++; if (led !== 8'h01) begin failures++; $display("FAIL esq_entry got=%h exp=01", led); end
    repeat (12) @(negedge clk_2);
    checks++; if (led !== 8'h08) begin failures++; $display("FAIL esq_pre_freeze got=%h exp=08", led); end
    @(negedge clk_2);
    parar = 1'b1;
    repeat (10) @(negedge clk_2);
    checks++; if (led !== 8'h08) begin failures++; $display("FAIL freeze_led got=%h exp=08", led); end
    checks++; if (passo !== 4'd3) begin failures++; $display("FAIL freeze_passo got=%0d exp=3", passo); end
    parar = 1'b0;
    repeat (2) @(negedge clk_2);
    checks++; if (led !== 8'h08) begin failures++; $display("FAIL resume_early got=%h exp=08", led); end
    @(negedge clk_2);
    checks++; if (led !== 8'h10) begin failures++; $display("FAIL resume_step got=%h exp=10", led); end
    checks++; if (passo !== 4'd4) begin failures++; $display("FAIL resume_passo got=%0d exp=4", passo); end
  endtask

  // Continues from test_freeze: led just stepped, prescaler at 0.
  task automatic test_switch_tick();
    modo_sel = 2'd0;
    @(negedge clk_2);
    checks++; if (led !== 8'h80) begin failures++; $display("FAIL switch_entry_dir got=%h exp=80", led); end
    repeat (3) @(negedge clk_2);
    checks++; if (led !== 8'h80) begin failures++; $display("FAIL switch_pre_tick got=%h exp=80", led); end
    modo_sel = 2'd1;
    @(negedge clk_2);
    checks++; if (led !== 8'h01) begin failures++; $display("FAIL switch_on_tick_led got=%h exp=01", led); end
    checks++; if (passo !== 4'd0) begin failures++; $display("FAIL switch_on_tick_passo got=%0d exp=0", passo); end
    checks++; if (modo_atual !== 2'd1) begin failures++; $display("FAIL switch_on_tick_modo got=%0d exp=1", modo_atual); end
    repeat (3) @(negedge clk_2);
    checks++; if (led !== 8'h01) begin failures++; $display("FAIL switch_cnt_cleared got=%h exp=01", led); end
    @(negedge clk_2);
    checks++; if (led !== 8'h02) begin failures++; $display("FAIL switch_first_step got=%h exp=02", led); end
  endtask

  task automatic test_auto_rotation();
    int n_fim = 0;
    int ciclo_fim = -1;
    auto = 1'b1;
    modo_sel = 2'd2;
    apply_reset();
    for (int i = 1; i <= 257; i++) begin
      @(negedge clk_2);
      if (fim_ciclo === 1'b1) begin n_fim++; ciclo_fim = i; end
      case (i)
        63: begin
          checks++; if (modo_atual !== 2'd0 || passo !== 4'd15 || led !== 8'h01) begin failures++;
            $display("FAIL auto_c63 got modo=%0d passo=%0d led=%h exp modo=0 passo=15 led=01", modo_atual, passo, led); end
        end
        64: begin
          checks++; if (modo_atual !== 2'd1 || passo !== 4'd0 || led !== 8'h01) begin failures++;
            $display("FAIL auto_c64 got modo=%0d passo=%0d led=%h exp modo=1 passo=0 led=01", modo_atual, passo, led); end
        end
        128: begin
          checks++; if (modo_atual !== 2'd2 || led !== 8'h01) begin failures++;
            $display("FAIL auto_c128 got modo=%0d led=%h exp modo=2 led=01", modo_atual, led); end
        end
        192: begin
          checks++; if (modo_atual !== 2'd3 || led !== 8'h00) begin failures++;
            $display("FAIL auto_c192 got modo=%0d led=%h exp modo=3 led=00", modo_atual, led); end
        end
        255: begin
          checks++; if (modo_atual !== 2'd3 || passo !== 4'd15 || led !== 8'h3F || fim_ciclo !== 1'b0) begin failures++;
            $display("FAIL auto_c255 got modo=%0d passo=%0d led=%h fim=%b exp modo=3 passo=15 led=3F fim=0", modo_atual, passo, led, fim_ciclo); end
        end
        256: begin
          checks++; if (modo_atual !== 2'd0 || led !== 8'h80 || fim_ciclo !== 1'b1) begin failures++;
            $display("FAIL auto_wrap got modo=%0d led=%h fim=%b exp modo=0 led=80 fim=1", modo_atual, led, fim_ciclo); end
        end
        257: begin
          checks++; if (fim_ciclo !== 1'b0) begin failures++; $display("FAIL fim_pulse_width got=%b exp=0", fim_ciclo); end
        end
        default: ;
      endcase
    end
    checks++; if (n_fim != 1 || ciclo_fim != 256) begin failures++;
      $display("FAIL fim_count got n=%0d at=%0d exp n=1 at=256", n_fim, ciclo_fim); end
    auto = 1'b0;
    @(negedge clk_2);
    checks++; if (modo_atual !== 2'd2 || led !== 8'h01 || passo !== 4'd0) begin failures++;
      $display("FAIL auto_to_manual got modo=%0d led=%h passo=%0d exp modo=2 led=01 passo=0", modo_atual, led, passo); end
  endtask

  initial begin
    reset    = 1'b1;
    parar    = 1'b0;
    auto     = 1'b0;
    modo_sel = 2'd0;
    #2;
    test_reset();
    test_chase_dir();
    test_bounce_fill();
    test_freeze();
    test_switch_tick();
    test_auto_rotation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
